// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared widths, FSM encoding and address field helpers for the data cache
package dcache_defines;
  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;
  localparam int TAG_W  = 11;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 2;
  localparam int LINE_W = 64;
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    ALLOC = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage with a combinational read port
// and a single synchronous write port (line fill, word merge or dirty clear).
module dcache_array
  import dcache_defines::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [TAG_W-1:0]  tag_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [LINE_W-1:0] line_o,
  input  logic              fill_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i,
  input  logic              word_we_i,
  input  logic [OFF_W-1:0]  word_off_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              clr_dirty_i
);
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tags and data are left unreset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][{word_off_i, 4'b0000} +: WORD_W] <= word_i;
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back/write-allocate data cache controller:
// hit detection, miss FSM, line-wide memory handshake and saturating hit/miss counters.
module dcache_ctrl
  import dcache_defines::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic [13:0]      mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata,
  input  logic             mem_rdy,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  state_t            state_q;
  logic [13:0]       miss_line_q;
  logic [15:0]       rdata_q;
  logic              mem_re_q, mem_we_q;
  logic [13:0]       mem_addr_q;
  logic [63:0]       mem_wdata_q;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic              is_idle, req, hit, idle_hit, idle_miss;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  arr_tag;
  logic              arr_valid, arr_dirty;
  logic [LINE_W-1:0] arr_line;
  logic [WORD_W-1:0] hit_word;

  assign is_idle   = (state_q == IDLE);
  assign req       = cpu_re | cpu_we;
  // Outside IDLE the CPU may drop its request, so the array follows the latched miss line.
  assign arr_idx   = is_idle ? addr_idx(cpu_addr) : miss_line_q[IDX_W-1:0];
  assign hit       = arr_valid && (arr_tag == addr_tag(cpu_addr));
  assign idle_hit  = is_idle && req && hit;
  assign idle_miss = is_idle && req && !hit;
  assign hit_word  = arr_line[{addr_off(cpu_addr), 4'b0000} +: WORD_W];

  assign cpu_stall = !is_idle || idle_miss;
  assign cpu_rdata = (idle_hit && !cpu_we) ? hit_word : rdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  assign hit_cnt_d  = (idle_hit  && hit_cnt_q  != '1) ? hit_cnt_q  + CNT_W'(1) : hit_cnt_q;
  assign miss_cnt_d = (idle_miss && miss_cnt_q != '1) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;

  dcache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (arr_idx),
    .tag_o       (arr_tag),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .line_o      (arr_line),
    .fill_i      ((state_q == ALLOC) && mem_rdy),
    .fill_tag_i  (miss_line_q[13 -: TAG_W]),
    .fill_line_i (mem_rdata),
    .word_we_i   (idle_hit && cpu_we),
    .word_off_i  (addr_off(cpu_addr)),
    .word_i      (cpu_wdata),
    .clr_dirty_i ((state_q == WB) && mem_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_line_q <= '0;
      rdata_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (idle_hit && !cpu_we) rdata_q <= hit_word;
      unique case (state_q)
        IDLE: begin
          if (idle_miss) begin
            miss_line_q <= cpu_addr[15:2];
            if (arr_valid && arr_dirty) begin
              state_q     <= WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {arr_tag, arr_idx};
              mem_wdata_q <= arr_line;
            end else begin
              state_q    <= ALLOC;
              mem_re_q   <= 1'b1;
              mem_addr_q <= cpu_addr[15:2];
            end
          end
        end
        WB: begin
          if (mem_rdy) begin
            state_q    <= ALLOC;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= miss_line_q;
          end
        end
        ALLOC: begin
          if (mem_rdy) begin
            state_q  <= IDLE;
            mem_re_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_re, cpu_we, cpu_stall;
  logic [13:0] mem_addr;
  logic        mem_re, mem_we, mem_rdy;
  logic [63:0] mem_wdata, mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  dcache_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // External memory, responder state and event log
  logic [63:0] bmem [16384];
  int          mem_lat = 3;
  logic        force_rdy = 1'b0;
  int          wb_cnt = 0;
  int          fill_cnt = 0;
  int          overlap = 0;
  logic [13:0] last_wb_addr;
  logic [63:0] last_wb_data;

  // Reference model: coherent memory view plus which line each set holds
  logic [15:0] ref_view [65536];
  int          res [8];
  bit          dirt [8];
  int          mh, mm;

  typedef struct {
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic        chk_rd;
    logic [15:0] exp_rd;
    int          exp_cyc;
    int          exp_wb;
    logic [13:0] wb_addr;
    logic [63:0] wb_data;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Presents one request and holds it until the cache accepts it; cyc counts stalled+accept cycles.
  task automatic access(input logic [15:0] a, input logic re, input logic we,
                        input logic [15:0] wd, output logic [15:0] rd, output int cyc);
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_wdata = wd;
    cyc = 0; rd = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (!cpu_stall) begin
        rd = cpu_rdata;
        break;
      end
      if (cyc > 200) break;
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  always @(negedge clk) if (mem_re && mem_we) overlap++;

  // Memory responder: mem_rdy pulses in the mem_lat-th cycle of each request
  initial begin : responder
    int  wcnt;
    int  cur_lat;
    bit  pend;
    pend = 0; wcnt = 0; cur_lat = 1;
    mem_rdy = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rdy = force_rdy;
      if (force_rdy) mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
      if (rst) begin
        pend = 0;
        mem_rdy = 1'b0;
      end else if (mem_re || mem_we) begin
        if (!pend) begin
          pend = 1; wcnt = 0; cur_lat = mem_lat;
        end else begin
          wcnt++;
        end
        if (wcnt >= cur_lat - 1) begin
          mem_rdy = 1'b1;
          pend = 0;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
            wb_cnt++;
          end else begin
            mem_rdata = bmem[mem_addr];
            fill_cnt++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [15:0] rd, a, wd, h0, m0;
    int          cyc, wb0, op, lat, line, s, ecyc, nwait;
    bit          hitm;
    logic        re, we;

    for (int l = 0; l < 16384; l++) begin
      logic [13:0] l14;
      l14 = l[13:0];
      bmem[l] = {init_word({l14, 2'd3}), init_word({l14, 2'd2}),
                 init_word({l14, 2'd1}), init_word({l14, 2'd0})};
    end
    bmem[4] = 64'h0004_0003_0002_0001;

    vecs[0] = '{16'h0012, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1, 0, 14'h0, 64'h0};
    vecs[1] = '{16'h0012, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1, 0, 14'h0, 64'h0};
    vecs[2] = '{16'h0030, 1'b1, 1'b0, 16'h0000, 1'b1, init_word(16'h0030), 8, 1,
                14'h004, 64'h0004_BEEF_0002_0001};
    vecs[3] = '{16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 5, 0, 14'h0, 64'h0};
    vecs[4] = '{16'h0012, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1, 0, 14'h0, 64'h0};
    vecs[5] = '{16'h0013, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1, 0, 14'h0, 64'h0};
    vecs[6] = '{16'h0013, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 1, 0, 14'h0, 64'h0};
    vecs[7] = '{16'h0011, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1, 0, 14'h0, 64'h0};

    rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", cpu_stall, 0);
    chk("reset mem_re", mem_re, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset cpu_rdata", cpu_rdata, 0);
    chk("reset hit_cnt", hit_cnt, 0);
    chk("reset miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold read miss
    mem_lat = 3;
    cpu_addr = 16'h0010; cpu_re = 1'b1;
    @(negedge clk);
    chk("cold stall same cycle", cpu_stall, 1);
    chk("cold mem_re not yet", mem_re, 0);
    @(negedge clk);
    chk("cold mem_re", mem_re, 1);
    chk("cold mem_we", mem_we, 0);
    chk("cold mem_addr", mem_addr, 14'h004);
    nwait = 0;
    while (cpu_stall && nwait < 50) begin
      @(negedge clk);
      nwait++;
    end
    chk("cold stall cycles after request", nwait, 3);
    chk("cold rdata", cpu_rdata, 16'h0001);
    @(posedge clk); #1;
    cpu_re = 1'b0;
    chk("cold miss_cnt", miss_cnt, 1);
    chk("cold hit_cnt", hit_cnt, 1);

    for (int i = 0; i < 8; i++) begin
      wb0 = wb_cnt;
      access(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].wdata, rd, cyc);
      chk($sformatf("vec%0d cycles", i), cyc, vecs[i].exp_cyc);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d writebacks", i), wb_cnt - wb0, vecs[i].exp_wb);
      if (vecs[i].exp_wb != 0) begin
        chk($sformatf("vec%0d wb addr", i), last_wb_addr, vecs[i].wb_addr);
        chk($sformatf("vec%0d wb data", i), last_wb_data, vecs[i].wb_data);
      end
    end
    chk("counters after table: hit", hit_cnt, 9);
    chk("counters after table: miss", miss_cnt, 3);

    // mem_rdy while idle must not disturb anything
    @(negedge clk); force_rdy = 1'b1;
    @(negedge clk); force_rdy = 1'b0;
    @(posedge clk); #1;
    chk("spurious rdy mem_re", mem_re, 0);
    access(16'h0012, 1'b1, 1'b0, 16'h0, rd, cyc);
    chk("spurious rdy cycles", cyc, 1);
    chk("spurious rdy rdata", rd, 16'hBEEF);

    // Request dropped mid-miss: line installed, no replay counted
    h0 = hit_cnt; m0 = miss_cnt;
    cpu_addr = 16'h0070; cpu_re = 1'b1;
    nwait = 0;
    do begin
      @(negedge clk);
      nwait++;
    end while (!mem_re && nwait < 50);
    chk("drop reached alloc", mem_re, 1);
    @(posedge clk); #1;
    cpu_re = 1'b0;
    nwait = 0;
    do begin
      @(negedge clk);
      nwait++;
    end while (cpu_stall && nwait < 50);
    chk("drop back to idle", cpu_stall, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("drop hit_cnt unchanged", hit_cnt, h0);
    chk("drop miss_cnt", miss_cnt, m0 + 16'd1);
    access(16'h0070, 1'b1, 1'b0, 16'h0, rd, cyc);
    chk("drop line installed cycles", cyc, 1);
    chk("drop line data", rd, init_word(16'h0070));

    // Reset during writeback
    access(16'h0040, 1'b0, 1'b1, 16'hDADA, rd, cyc);
    chk("dirty set0 cycles", cyc, 5);
    mem_lat = 10;
    cpu_addr = 16'h0100; cpu_re = 1'b1;
    nwait = 0;
    do begin
      @(negedge clk);
      nwait++;
    end while (!mem_we && nwait < 50);
    chk("rst-wb mem_we", mem_we, 1);
    chk("rst-wb mem_addr", mem_addr, 14'h010);
    chk("rst-wb mem_wdata word0", mem_wdata[15:0], 16'hDADA);
    #2;
    rst = 1'b1; cpu_re = 1'b0;
    #1;
    chk("rst-wb mem_we drops", mem_we, 0);
    chk("rst-wb mem_re", mem_re, 0);
    chk("rst-wb hit_cnt", hit_cnt, 0);
    chk("rst-wb miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mem_lat = 3;

    for (int i = 0; i < 65536; i++) ref_view[i] = bmem[i >> 2][(i % 4) * 16 +: 16];
    for (int i = 0; i < 8; i++) begin res[i] = -1; dirt[i] = 0; end
    mh = 0; mm = 0;

    access(16'h0040, 1'b1, 1'b0, 16'h0, rd, cyc);
    chk("after rst miss cycles", cyc, 5);
    chk("after rst data lost write", rd, init_word(16'h0040));
    chk("after rst miss_cnt", miss_cnt, 1);
    chk("after rst hit_cnt", hit_cnt, 1);
    res[0] = 16'h0040 >> 2; mh = 1; mm = 1;

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      a   = 16'($urandom_range(0, 127));
      op  = $urandom_range(0, 3);
      lat = $urandom_range(1, 4);
      wd  = 16'($urandom);
      re  = (op != 2);
      we  = (op >= 2);
      line = int'(a) >> 2;
      s    = line % 8;
      hitm = (res[s] == line);
      ecyc = hitm ? 1 : 2 + lat + ((res[s] >= 0 && dirt[s]) ? lat : 0);
      mem_lat = lat;
      access(a, re, we, wd, rd, cyc);
      chk($sformatf("rnd%0d cycles a=%0h", n, a), cyc, ecyc);
      if (!we) chk($sformatf("rnd%0d rdata a=%0h", n, a), rd, ref_view[a]);
      if (!hitm) begin
        mm++;
        res[s] = line;
        dirt[s] = 0;
      end
      mh++;
      if (we) begin
        ref_view[a] = wd;
        dirt[s] = 1;
      end
    end
    chk("final hit_cnt", hit_cnt, mh);
    chk("final miss_cnt", miss_cnt, mm);
    chk("mem_re and mem_we never together", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
